// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_STALL,
    ST_FLUSH,
    ST_HALT
  } fetch_state_t;

  // Next-PC source select for the fetch-stage PC register.
  typedef enum logic [1:0] {
    SEL_RST,
    SEL_HOLD,
    SEL_SEQ,
    SEL_TGT
  } pc_sel_t;

  localparam logic [3:0] HALT_OP = 4'hF;

endpackage

// File: rtl/fetch_stall_timer.sv
// Load-use stall timer: 3-bit down-counter with load/clear, zero and last-cycle flags.
module stall_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       clear,
  input  logic       dec,
  output logic       zero,
  output logic       last
);

  logic [2:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
    end else if (clear) begin
      count <= 3'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 3'd0)) begin
      count <= count - 3'd1;
    end
  end

  assign zero = (count == 3'd0);
  // The stall ends on the edge where the count reaches zero.
  assign last = (count == 3'd1);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: FSM choosing the next PC source, IF/ID qualifiers and fetch count.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                PWIDTH  = 16,
  parameter int                IWIDTH  = 24,
  parameter logic [PWIDTH-1:0] RST_VEC = '0,
  parameter int                LD_LAT  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PWIDTH-1:0] pc_i,
  input  logic [PWIDTH-1:0] pc_plus1_i,
  input  logic [IWIDTH-1:0] instr_i,
  input  logic              branch_taken_i,
  input  logic [PWIDTH-1:0] branch_target_i,
  input  logic              ld_use_i,
  input  logic              resume_i,
  output logic [PWIDTH-1:0] next_pc_o,
  output logic              if_valid_o,
  output logic              flush_o,
  output logic              halted_o,
  output logic [15:0]       fetch_cnt_o
);

  localparam logic [2:0] STALL_LOAD = 3'(LD_LAT - 1);
  localparam bit         MULTI_STALL = (LD_LAT > 1);

  fetch_state_t state_q, state_d;
  pc_sel_t      sel;
  logic         valid, flush;
  logic         t_load, t_clear, t_dec, t_zero, t_last;
  logic         is_halt;
  logic         unused_instr;

  assign is_halt      = (instr_i[IWIDTH-1 -: 4] == HALT_OP);
  assign unused_instr = ^instr_i[IWIDTH-5:0];

  stall_timer u_timer (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .load     (t_load),
    .load_val (STALL_LOAD),
    .clear    (t_clear),
    .dec      (t_dec),
    .zero     (t_zero),
    .last     (t_last)
  );

  // Priority within a state: branch, then load-use, then halt opcode, then sequential.
  always_comb begin
    state_d = state_q;
    sel     = SEL_HOLD;
    valid   = 1'b0;
    flush   = 1'b0;
    t_load  = 1'b0;
    t_clear = 1'b0;
    t_dec   = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        sel     = SEL_RST;
        flush   = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken_i) begin
          sel     = SEL_TGT;
          flush   = 1'b1;
          state_d = ST_FLUSH;
        end else if (ld_use_i) begin
          sel     = SEL_HOLD;
          t_load  = 1'b1;
          state_d = MULTI_STALL ? ST_STALL : ST_RUN;
        end else if (is_halt) begin
          sel     = SEL_HOLD;
          valid   = 1'b1;
          state_d = ST_HALT;
        end else begin
          sel   = SEL_SEQ;
          valid = 1'b1;
        end
      end
      ST_STALL: begin
        if (branch_taken_i) begin
          sel     = SEL_TGT;
          flush   = 1'b1;
          t_clear = 1'b1;
          state_d = ST_FLUSH;
        end else begin
          sel   = SEL_HOLD;
          t_dec = 1'b1;
          if (t_last || t_zero) state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (branch_taken_i) begin
          sel   = SEL_TGT;
          flush = 1'b1;
        end else begin
          sel     = SEL_SEQ;
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        // Pipeline is drained here, so a late branch has nothing to redirect.
        if (resume_i) begin
          sel     = SEL_SEQ;
          state_d = ST_RUN;
        end
      end
      default: begin
        sel     = SEL_RST;
        flush   = 1'b1;
        state_d = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    unique case (sel)
      SEL_RST:  next_pc_o = RST_VEC;
      SEL_HOLD: next_pc_o = pc_i;
      SEL_SEQ:  next_pc_o = pc_plus1_i;
      SEL_TGT:  next_pc_o = branch_target_i;
      default:  next_pc_o = RST_VEC;
    endcase
  end

  assign if_valid_o = valid;
  assign flush_o    = flush;
  assign halted_o   = (state_q == ST_HALT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_BOOT;
      fetch_cnt_o <= 16'd0;
    end else begin
      state_q <= state_d;
      if (valid) fetch_cnt_o <= fetch_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models the fetch-stage PC register and instruction memory around the DUT.
module tb_fetch_ctrl;

  typedef struct {
    logic        br;
    logic [15:0] tgt;
    logic        ld;
    logic        res;
    logic [15:0] nxt;
    logic        vld;
    logic        fl;
    logic        hlt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc;
  logic [15:0] pc_plus1;
  logic [23:0] instr;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        ld_use = 1'b0;
  logic        resume = 1'b0;
  logic        halt_en = 1'b1;
  logic [15:0] next_pc;
  logic        if_valid, flush, halted;
  logic [15:0] fetch_cnt;

  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;
  vec_t sb[$];
  vec_t tbl[29];

  always #5 clk = ~clk;

  fetch_ctrl #(.PWIDTH(16), .IWIDTH(24), .RST_VEC(16'h0000), .LD_LAT(3)) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .pc_i            (pc),
    .pc_plus1_i      (pc_plus1),
    .instr_i         (instr),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .ld_use_i        (ld_use),
    .resume_i        (resume),
    .next_pc_o       (next_pc),
    .if_valid_o      (if_valid),
    .flush_o         (flush),
    .halted_o        (halted),
    .fetch_cnt_o     (fetch_cnt)
  );

  // Fetch-stage PC register and instruction memory (halt opcode only at 0x10).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 16'h0;
    else        pc <= next_pc;
  end
  assign pc_plus1 = pc + 16'd1;
  assign instr    = (halt_en && pc == 16'h0010) ? 24'hF00000 : {8'h0A, pc};

  function automatic vec_t mk(input logic b, input logic [15:0] t, input logic l, input logic r,
                              input logic [15:0] n, input logic v, input logic f, input logic h);
    vec_t x;
    x.br = b; x.tgt = t; x.ld = l; x.res = r;
    x.nxt = n; x.vld = v; x.fl = f; x.hlt = h;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    branch_taken  = v.br;
    branch_target = v.tgt;
    ld_use        = v.ld;
    resume        = v.res;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, " next_pc"},   32'(next_pc),   32'(e.nxt));
    chk({tag, " if_valid"},  32'(if_valid),  32'(e.vld));
    chk({tag, " flush"},     32'(flush),     32'(e.fl));
    chk({tag, " halted"},    32'(halted),    32'(e.hlt));
    chk({tag, " fetch_cnt"}, 32'(fetch_cnt), 32'(exp_cnt));
    if (e.vld) exp_cnt++;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    ld_use       = 1'b0;
    resume       = 1'b0;
  endtask

  task automatic chk_boot(input string tag);
    chk({tag, " next_pc"},   32'(next_pc),   32'h0);
    chk({tag, " if_valid"},  32'(if_valid),  32'h0);
    chk({tag, " flush"},     32'(flush),     32'h1);
    chk({tag, " halted"},    32'(halted),    32'h0);
    chk({tag, " fetch_cnt"}, 32'(fetch_cnt), 32'h0);
  endtask

  initial begin
    //              br  tgt      ld   res   next     vld  fl   hlt
    tbl[0]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); // BOOT
    tbl[1]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 16'h40, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b1, 1'b0); // branch at 5
    tbl[7]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0041, 1'b0, 1'b0, 1'b0); // FLUSH
    tbl[8]  = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(1'b1, 16'h07, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 16'h0,  1'b1, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0); // ld_use ignored in FLUSH
    tbl[11] = mk(1'b0, 16'h0,  1'b1, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0); // load-use at 8
    tbl[12] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0009, 1'b1, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 16'h0,  1'b1, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(1'b1, 16'h0F, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b1, 1'b0); // branch in STALL
    tbl[17] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0);
    tbl[18] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0); // halt opcode
    tbl[19] = mk(1'b1, 16'h80, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1); // branch ignored
    tbl[20] = mk(1'b0, 16'h0,  1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1);
    tbl[21] = mk(1'b0, 16'h0,  1'b0, 1'b1, 16'h0011, 1'b0, 1'b0, 1'b1); // resume
    tbl[22] = mk(1'b1, 16'h20, 1'b0, 1'b0, 16'h0020, 1'b0, 1'b1, 1'b0);
    tbl[23] = mk(1'b1, 16'h30, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b1, 1'b0); // branch in FLUSH
    tbl[24] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0031, 1'b0, 1'b0, 1'b0);
    tbl[25] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0032, 1'b1, 1'b0, 1'b0);
    tbl[26] = mk(1'b1, 16'h50, 1'b1, 1'b0, 16'h0050, 1'b0, 1'b1, 1'b0); // branch beats ld_use
    tbl[27] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0051, 1'b0, 1'b0, 1'b0);
    tbl[28] = mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0052, 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    chk_boot("in_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 29; i++) run_vec(tbl[i], $sformatf("row%0d", i));

    // Async reset in the middle of a stall.
    run_vec(mk(1'b0, 16'h0, 1'b1, 1'b0, 16'h0052, 1'b0, 1'b0, 1'b0), "stall_a");
    run_vec(mk(1'b0, 16'h0, 1'b0, 1'b0, 16'h0052, 1'b0, 1'b0, 1'b0), "stall_b");
    #2 rst_n = 1'b0;
    #1 chk_boot("rst_stall");
    exp_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reach HALT again, then reset from there.
    run_vec(mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0), "h_boot");
    run_vec(mk(1'b1, 16'h0F, 1'b0, 1'b0, 16'h000F, 1'b0, 1'b1, 1'b0), "h_br");
    run_vec(mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0), "h_flush");
    run_vec(mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0), "h_op");
    run_vec(mk(1'b0, 16'h0,  1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1), "h_halt");
    #2 rst_n = 1'b0;
    #1 chk_boot("rst_halt");
    exp_cnt = 0;
    halt_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // One BOOT edge then 65535 issuing edges bring the counter to 0xFFFF.
    repeat (65536) @(posedge clk);
    @(negedge clk);
    chk("cnt_max", 32'(fetch_cnt), 32'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("cnt_wrap", 32'(fetch_cnt), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
